// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller and its
// sequential binary-to-BCD converter.
package seg_pkg;

   localparam int              SEG_DIGITS  = 4;
   localparam int              SEG_BIN_W   = 14;
   localparam logic [13:0]     SEG_MAX_VAL = 14'd9999;
   localparam logic [3:0]      SEG_AN_OFF  = 4'b1111;

   typedef enum logic {
      IDLE,
      CONV
   } conv_state_t;

   function automatic logic [3:0] seg_nibble(input logic [15:0] bcd, input logic [1:0] idx);
      return bcd[{idx, 2'b00} +: 4];
   endfunction

   // True when nibble idx and every more significant nibble are zero.
   function automatic logic seg_upper_zero(input logic [15:0] bcd, input logic [1:0] idx);
      return (bcd >> {idx, 2'b00}) == 16'h0000;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake and display-drive signals of the scan controller.
interface seg_scan_ctrl_if;
   import seg_pkg::*;

   logic                  load;
   logic [SEG_BIN_W-1:0]  value;
   logic                  blank_lz;
   logic                  busy;
   logic                  ovf;
   logic [3:0]            digit_num;
   logic [SEG_DIGITS-1:0] an;

   modport master (
      output load, value, blank_lz,
      input  busy, ovf, digit_num, an
   );

   modport slave (
      input  load, value, blank_lz,
      output busy, ovf, digit_num, an
   );

endinterface

// File: rtl/seg_scan_ctrl_bin2bcd.sv
// Sequential double-dabble converter: 14 iterations, one per clock, after
// a start accepted in IDLE. done pulses with the final result on bcd.
module bin2bcd_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [13:0] bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd
);
   import seg_pkg::*;

   conv_state_t r_state, w_next_state;
   logic [3:0]  r_iter;
   logic [13:0] r_bin;
   logic [15:0] r_bcd;
   logic [15:0] w_adj;
   logic [29:0] w_shift;

   always_comb begin
      w_adj = '0;
      for (int i = 0; i < 4; i++) begin
         w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
      end
      w_shift = {w_adj, r_bin} << 1;
   end

   assign bcd = w_shift[29:14];

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: if (start) w_next_state = CONV;
         CONV: begin
            busy = 1'b1;
            if (r_iter == 4'd13) begin
               done         = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_iter  <= '0;
         r_bin   <= '0;
         r_bcd   <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == IDLE) begin
            if (start) begin
               r_bin  <= bin;
               r_bcd  <= '0;
               r_iter <= '0;
            end
         end else begin
            r_bcd  <= w_shift[29:14];
            r_bin  <= w_shift[13:0];
            r_iter <= r_iter + 4'd1;
         end
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller: saturating load, BCD
// conversion, digit scan and anode drive aligned to the decoder's output register.
module seg_scan_ctrl #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic            clk,
   input  logic            rst,
   seg_scan_ctrl_if.slave  bus
);
   import seg_pkg::*;

   localparam int PW = $clog2(REFRESH_DIV);

   logic [PW-1:0]        r_presc;
   logic [1:0]           r_idx;
   logic [1:0]           r_slot_idx;
   logic                 r_slot_blank;
   logic [15:0]          r_disp;
   logic [3:0]           r_digit_num;
   logic [3:0]           r_an;
   logic                 r_ovf;
   logic                 w_conv_busy;
   logic                 w_done;
   logic                 w_accept;
   logic                 w_blank;
   logic [SEG_BIN_W-1:0] w_bin_sat;
   logic [15:0]          w_bcd;

   assign w_accept  = bus.load && !w_conv_busy;
   assign w_bin_sat = (bus.value > SEG_MAX_VAL) ? SEG_MAX_VAL : bus.value;
   assign w_blank   = bus.blank_lz && (r_idx != 2'd0) && seg_upper_zero(r_disp, r_idx);

   bin2bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (bus.load),
      .bin   (w_bin_sat),
      .busy  (w_conv_busy),
      .done  (w_done),
      .bcd   (w_bcd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc      <= '0;
         r_idx        <= '0;
         r_slot_idx   <= '0;
         r_slot_blank <= 1'b1;  // no slot has been presented yet
         r_digit_num  <= '0;
         r_an         <= SEG_AN_OFF;
         r_disp       <= '0;
         r_ovf        <= 1'b0;
      end else begin
         if (r_presc == PW'(REFRESH_DIV - 1)) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
         // Slot stage: nibble to the decoder; anode follows one cycle later.
         r_digit_num  <= seg_nibble(r_disp, r_idx);
         r_slot_idx   <= r_idx;
         r_slot_blank <= w_blank;
         r_an         <= r_slot_blank ? SEG_AN_OFF : ~(4'b0001 << r_slot_idx);
         if (w_done)   r_disp <= w_bcd;
         if (w_accept) r_ovf  <= (bus.value > SEG_MAX_VAL);
      end
   end

   assign bus.busy      = w_conv_busy;
   assign bus.ovf       = r_ovf;
   assign bus.digit_num = r_digit_num;
   assign bus.an        = r_an;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: cycle-level timeline model plus
// table-driven load vectors and hand-written abort/ignore sequences.
module tb_seg_scan_ctrl;
   import seg_pkg::*;

   localparam int DIV = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   seg_scan_ctrl_if bus ();

   seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Timeline model: edges since reset, display contents, pending conversion.
   int          m_n, m_done_edge;
   logic        m_busy, m_ovf;
   logic [15:0] m_disp, m_pending;
   logic [3:0]  m_dn, m_an;
   logic        m_pvalid, m_pblank;
   int          m_pidx;

   typedef struct {
      logic [13:0] value;
      logic        blz;
      logic [15:0] disp;
      logic        ovf;
      logic [3:0]  lit;
   } vec_t;

   vec_t vecs [10];

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      int  idx;
      logic [3:0] mask;
      @(posedge clk);
      if (rst) begin
         m_n = 0; m_done_edge = 0; m_busy = 1'b0; m_ovf = 1'b0;
         m_disp = '0; m_dn = '0; m_an = SEG_AN_OFF; m_pvalid = 1'b0;
      end else begin
         m_n++;
         idx  = ((m_n - 1) / DIV) % 4;
         mask = 4'b0001 << m_pidx;
         m_an = (m_pvalid && !m_pblank) ? ~mask : SEG_AN_OFF;
         m_dn = m_disp[4*idx +: 4];
         m_pvalid = 1'b1;
         m_pidx   = idx;
         m_pblank = bus.blank_lz && idx > 0 && ((m_disp >> (4 * idx)) == 16'h0);
         if (m_busy && m_n == m_done_edge) m_disp = m_pending;
         if (bus.load && !m_busy) begin
            m_pending   = to_bcd(int'(bus.value) > 9999 ? 9999 : int'(bus.value));
            m_done_edge = m_n + 14;
            m_ovf       = int'(bus.value) > 9999;
         end
         m_busy = m_n < m_done_edge;
      end
      #1;
      check("busy", bus.busy, m_busy);
      check("ovf", bus.ovf, m_ovf);
      check("digit_num", bus.digit_num, m_dn);
      check("an", bus.an, m_an);
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (bus.busy && cycles < 40) begin
         step();
         cycles++;
      end
   endtask

   // Reconstruct the displayed digits from the outputs over one full scan.
   task automatic observe(input string tag, input logic [15:0] exp_disp, input logic [3:0] exp_lit);
      logic [3:0]  prev_dn, lit, mask;
      logic [15:0] obs;
      step();
      step();
      lit = '0; obs = '0; prev_dn = bus.digit_num;
      for (int c = 0; c < 4 * DIV + 2; c++) begin
         step();
         for (int i = 0; i < 4; i++) begin
            mask = ~(4'b0001 << i);
            if (bus.an == mask) begin
               lit[i] = 1'b1;
               obs[4*i +: 4] = prev_dn;
            end
         end
         prev_dn = bus.digit_num;
      end
      check({tag, " lit"}, lit, exp_lit);
      for (int i = 0; i < 4; i++)
         if (exp_lit[i]) check({tag, " digit"}, obs[4*i +: 4], exp_disp[4*i +: 4]);
   endtask

   task automatic do_load(input logic [13:0] v);
      int cyc;
      bus.load = 1'b1; bus.value = v;
      step();
      bus.load = 1'b0;
      wait_idle(cyc);
      check("busy cycles", cyc, 14);
   endtask

   initial begin
      int cyc;
      vecs[0] = '{14'd1234,  1'b0, 16'h1234, 1'b0, 4'b1111};
      vecs[1] = '{14'd42,    1'b1, 16'h0042, 1'b0, 4'b0011};
      vecs[2] = '{14'd42,    1'b0, 16'h0042, 1'b0, 4'b1111};
      vecs[3] = '{14'd12000, 1'b0, 16'h9999, 1'b1, 4'b1111};
      vecs[4] = '{14'd5,     1'b1, 16'h0005, 1'b0, 4'b0001};
      vecs[5] = '{14'd0,     1'b1, 16'h0000, 1'b0, 4'b0001};
      vecs[6] = '{14'd16383, 1'b1, 16'h9999, 1'b1, 4'b1111};
      vecs[7] = '{14'd9999,  1'b0, 16'h9999, 1'b0, 4'b1111};
      vecs[8] = '{14'd10000, 1'b1, 16'h9999, 1'b1, 4'b1111};
      vecs[9] = '{14'd100,   1'b1, 16'h0100, 1'b0, 4'b0111};

      rst = 1'b1; bus.load = 1'b0; bus.value = '0; bus.blank_lz = 1'b1;
      m_pidx = 0; m_pblank = 1'b1;
      step();
      step();
      check("rst an", bus.an, SEG_AN_OFF);
      check("rst digit_num", bus.digit_num, 0);
      check("rst busy", bus.busy, 0);
      check("rst ovf", bus.ovf, 0);
      rst = 1'b0;
      observe("rst scan", 16'h0000, 4'b0001);

      for (int v = 0; v < 10; v++) begin
         bus.blank_lz = vecs[v].blz;
         do_load(vecs[v].value);
         check("vec ovf", bus.ovf, vecs[v].ovf);
         observe("vec", vecs[v].disp, vecs[v].lit);
      end

      // Load during conversion is ignored.
      bus.blank_lz = 1'b0;
      bus.load = 1'b1; bus.value = 14'd1111;
      step();
      bus.load = 1'b0;
      step();
      step();
      bus.load = 1'b1; bus.value = 14'd7777;
      step();
      bus.load = 1'b0;
      wait_idle(cyc);
      check("ignored load tail", cyc, 11);
      check("ignored load ovf", bus.ovf, 0);
      observe("ignored load", 16'h1111, 4'b1111);

      // Reset mid-conversion aborts and clears the display.
      bus.load = 1'b1; bus.value = 14'd5678;
      step();
      bus.load = 1'b0;
      for (int i = 0; i < 6; i++) step();
      rst = 1'b1;
      step();
      check("abort busy", bus.busy, 0);
      check("abort an", bus.an, SEG_AN_OFF);
      check("abort digit_num", bus.digit_num, 0);
      rst = 1'b0;
      step();
      step();
      check("abort restart an", bus.an, 4'b1110);
      observe("abort", 16'h0000, 4'b1111);

      // Randomized traffic against the timeline model.
      for (int c = 0; c < 600; c++) begin
         rst      = ($urandom_range(0, 149) == 0);
         bus.load = ($urandom_range(0, 7) == 0);
         bus.value = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 120))
                                                 : 14'($urandom_range(0, 16383));
         if ($urandom_range(0, 31) == 0) bus.blank_lz = ~bus.blank_lz;
         step();
      end
      rst = 1'b0; bus.load = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
